// File: rtl/wavetable_mixer.sv
// Multi-voice wavetable synthesizer: per-voice phase accumulators share one
// synchronous ROM port, and the attenuated voices are summed into one saturated sample per request.
module wavetable_mixer #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned SAMPLE_W   = 32,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned TABLE_AW   = 8,
    parameter int unsigned VOL_W      = 3
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           sample_req,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*PHASE_W-1:0]  phase_inc,
    input  logic [NUM_VOICES*VOL_W-1:0]    vol,
    output logic [TABLE_AW-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]            rom_q,
    output logic [SAMPLE_W-1:0]            sample,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int unsigned ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int unsigned IDX_W  = $clog2(NUM_VOICES + 2);
    localparam int unsigned VSEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned HI_W   = ACC_W - SAMPLE_W + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic [PHASE_W-1:0]        phase  [NUM_VOICES];
    logic [PHASE_W-1:0]        inc_sh [NUM_VOICES];
    logic [VOL_W-1:0]          vol_sh [NUM_VOICES];
    logic [NUM_VOICES-1:0]     en_sh;

    logic [VSEL_W-1:0]         wr_voice;
    logic [VSEL_W-1:0]         rd_voice;
    logic [PHASE_W-1:0]        addr_phase;
    logic [VOL_W-1:0]          rd_vol;
    logic signed [SAMPLE_W-1:0] shifted;
    logic signed [SAMPLE_W-1:0] att;
    logic signed [ACC_W-1:0]   sum;
    logic [HI_W-1:0]           sum_hi;
    logic [SAMPLE_W-1:0]       sum_sat;

    // idx addresses the voice being read; idx-1 is the voice whose ROM data is on rom_q
    always_comb begin
        wr_voice   = VSEL_W'(idx);
        rd_voice   = VSEL_W'(idx - IDX_W'(1));
        addr_phase = phase[wr_voice];
        rom_addr   = '0;
        if (state == RUN && idx < IDX_W'(NUM_VOICES)) begin
            rom_addr = addr_phase[PHASE_W-1 -: TABLE_AW];
        end
        rd_vol  = vol_sh[rd_voice];
        shifted = $signed(rom_q) >>> rd_vol;
        att     = '0;
        if (en_sh[rd_voice] && !(&rd_vol)) begin
            att = shifted;
        end
        sum     = acc + {{(ACC_W-SAMPLE_W){att[SAMPLE_W-1]}}, att};
        sum_hi  = sum[ACC_W-1:SAMPLE_W-1];
        sum_sat = sum[SAMPLE_W-1:0];
        if (!(&sum_hi) && (|sum_hi)) begin
            sum_sat = sum[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                   : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            en_sh        <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i]  <= '0;
                inc_sh[i] <= '0;
                vol_sh[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            inc_sh[i] <= phase_inc[i*PHASE_W +: PHASE_W];
                            vol_sh[i] <= vol[i*VOL_W +: VOL_W];
                        end
                        en_sh <= voice_en;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (sample_req) begin
                        overrun <= 1'b1;
                    end
                    idx <= idx + IDX_W'(1);
                    // phase advances as its address is registered by the ROM
                    if (idx < IDX_W'(NUM_VOICES)) begin
                        phase[wr_voice] <= en_sh[wr_voice] ? addr_phase + inc_sh[wr_voice]
                                                           : '0;
                    end
                    if (idx != '0) begin
                        acc <= sum;
                    end
                    if (idx == IDX_W'(NUM_VOICES)) begin
                        sample       <= sum_sat;
                        sample_valid <= 1'b1;
                        busy         <= 1'b0;
                        idx          <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wavetable_mixer.sv
// Directed bench for wavetable_mixer with a synchronous 1-cycle ROM model.
module tb_wavetable_mixer;

    localparam int unsigned NV = 4;
    localparam int unsigned SW = 32;
    localparam int unsigned PW = 24;
    localparam int unsigned AW = 8;
    localparam int unsigned VW = 3;

    logic              CLOCK_50;
    logic              reset;
    logic              sample_req;
    logic [NV-1:0]     voice_en;
    logic [NV*PW-1:0]  phase_inc;
    logic [NV*VW-1:0]  vol;
    logic [AW-1:0]     rom_addr;
    logic [SW-1:0]     rom_q;
    logic [SW-1:0]     sample;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    logic [SW-1:0]     rom_mem [0:255];
    int                vectors;
    int                miscompares;

    wavetable_mixer #(
        .NUM_VOICES(NV), .SAMPLE_W(SW), .PHASE_W(PW), .TABLE_AW(AW), .VOL_W(VW)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sample_req(sample_req),
        .voice_en(voice_en), .phase_inc(phase_inc), .vol(vol),
        .rom_addr(rom_addr), .rom_q(rom_q), .sample(sample),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rom_q <= rom_mem[rom_addr];

    task automatic fill_ramp(input int base);
        for (int a = 0; a < 256; a++) rom_mem[a] = SW'(a * 1000 + base);
    endtask

    task automatic fill_const(input logic [SW-1:0] v);
        for (int a = 0; a < 256; a++) rom_mem[a] = v;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
    endtask

    // One frame; optional vol/en change after edge chg_at; lat=-1 if no valid within budget
    task automatic run_frame(input int chg_at, input logic [NV*VW-1:0] nvol,
                             input logic [NV-1:0] nen,
                             output logic [SW-1:0] s, output int lat);
        sample_req = 1'b1;
        @(posedge CLOCK_50);
        #1 sample_req = 1'b0;
        lat = -1;
        s   = 'x;
        for (int e = 1; e <= 12; e++) begin
            @(posedge CLOCK_50);
            #1;
            if (e == chg_at) begin
                vol      = nvol;
                voice_en = nen;
            end
            if (sample_valid) begin
                lat = e;
                s   = sample;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        vectors++;
        if (sample !== '0 || sample_valid !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_state: sample=%h valid=%b busy=%b overrun=%b addr=%h required all 0",
                     sample, sample_valid, busy, overrun, rom_addr);
        end
        apply_reset;
    endtask

    task automatic test_single_voice;
        logic [SW-1:0] s;
        int lat;
        apply_reset;
        fill_ramp(0);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h010000};
        vol       = '0;
        for (int i = 0; i <= 256; i++) begin
            run_frame(-1, '0, '0, s, lat);
            vectors++;
            if (s !== SW'((i % 256) * 1000) || lat != 5) begin
                miscompares++;
                $display("FAIL single_voice frame %0d: sample=%0d lat=%0d required %0d lat 5",
                         i, $signed(s), lat, (i % 256) * 1000);
            end
            if (i == 3) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL busy_end: busy=%b required 0", busy);
                end
                @(posedge CLOCK_50);
                #1;
                vectors++;
                if (sample_valid !== 1'b0 || sample !== SW'(3000)) begin
                    miscompares++;
                    $display("FAIL valid_pulse: valid=%b sample=%0d required 0 and hold 3000",
                             sample_valid, $signed(sample));
                end
            end
        end
    endtask

    task automatic test_attenuation;
        logic [SW-1:0] s;
        int lat;
        fill_ramp(0);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h010000};
        apply_reset;
        vol = 12'h002;
        run_frame(-1, '0, '0, s, lat);
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(250)) begin
            miscompares++;
            $display("FAIL atten_vol2: sample=%0d required 250", $signed(s));
        end
        apply_reset;
        vol = 12'h007;
        run_frame(-1, '0, '0, s, lat);
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(0) || lat != 5) begin
            miscompares++;
            $display("FAIL atten_mute: sample=%0d lat=%0d required 0 lat 5", $signed(s), lat);
        end
        apply_reset;
        rom_mem[0] = 32'hFFFF_FC18;
        vol = 12'h001;
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== 32'hFFFF_FE0C) begin
            miscompares++;
            $display("FAIL atten_neg: sample=%0d required -500", $signed(s));
        end
        rom_mem[0] = '0;
    endtask

    task automatic test_saturation;
        logic [SW-1:0] s;
        int lat;
        apply_reset;
        voice_en  = 4'b1111;
        phase_inc = '0;
        vol       = '0;
        fill_const(32'h7000_0000);
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== 32'h7FFF_FFFF) begin
            miscompares++;
            $display("FAIL sat_pos: sample=%h required 7fffffff", s);
        end
        fill_const(32'h9000_0000);
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL sat_neg: sample=%h required 80000000", s);
        end
        apply_reset;
        fill_const('0);
        rom_mem[1] = 32'h4000_0000;
        rom_mem[2] = 32'hF000_0000;
        voice_en  = 4'b0011;
        phase_inc = {24'h0, 24'h0, 24'h020000, 24'h010000};
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== '0) begin
            miscompares++;
            $display("FAIL mix_first: sample=%h required 0", s);
        end
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== 32'h3000_0000) begin
            miscompares++;
            $display("FAIL mix_two: sample=%h required 30000000", s);
        end
    endtask

    task automatic test_back_to_back;
        int acc_edge [8];
        int n_acc;
        int n_s;
        logic [SW-1:0] samp [4];
        logic prev_busy;
        apply_reset;
        fill_ramp(0);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h010000};
        vol       = '0;
        n_acc = 0;
        n_s   = 0;
        prev_busy = busy;
        sample_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (busy && !prev_busy && n_acc < 8) begin
                acc_edge[n_acc] = i;
                n_acc++;
            end
            if (sample_valid && n_s < 4) begin
                samp[n_s] = sample;
                n_s++;
            end
            prev_busy = busy;
        end
        sample_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (sample_valid && n_s < 4) begin
                samp[n_s] = sample;
                n_s++;
            end
        end
        vectors++;
        if (n_acc != 4 || n_s != 4) begin
            miscompares++;
            $display("FAIL held_req_count: accepts=%0d samples=%0d required 4 and 4", n_acc, n_s);
        end
        for (int k = 0; k < n_acc && k < 4; k++) begin
            vectors++;
            if (acc_edge[k] != 6 * k) begin
                miscompares++;
                $display("FAIL held_req_accept %0d: edge=%0d required %0d", k, acc_edge[k], 6 * k);
            end
        end
        for (int k = 0; k < n_s; k++) begin
            vectors++;
            if (samp[k] !== SW'(k * 1000)) begin
                miscompares++;
                $display("FAIL held_req_sample %0d: sample=%0d required %0d",
                         k, $signed(samp[k]), k * 1000);
            end
        end
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: overrun=%b required 1", overrun);
        end
        // request landing exactly on the final edge is an overrun, not a new frame
        apply_reset;
        sample_req = 1'b1;
        @(posedge CLOCK_50);
        #1 sample_req = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        #1;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_early: overrun=%b required 0", overrun);
        end
        sample_req = 1'b1;
        @(posedge CLOCK_50);
        #1 sample_req = 1'b0;
        vectors++;
        if (sample_valid !== 1'b1 || overrun !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_final_edge: valid=%b overrun=%b busy=%b required 1 1 0",
                     sample_valid, overrun, busy);
        end
        @(posedge CLOCK_50);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL final_edge_ignored: busy=%b required 0", busy);
        end
    endtask

    task automatic test_shadowing;
        logic [SW-1:0] s;
        int lat;
        apply_reset;
        fill_ramp(0);
        voice_en  = 4'b0001;
        phase_inc = {24'h0, 24'h0, 24'h0, 24'h010000};
        vol       = '0;
        run_frame(-1, '0, '0, s, lat);
        run_frame(1, 12'h007, 4'b0001, s, lat);
        vectors++;
        if (s !== SW'(1000)) begin
            miscompares++;
            $display("FAIL vol_shadow: sample=%0d required 1000", $signed(s));
        end
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(0)) begin
            miscompares++;
            $display("FAIL vol_next_frame: sample=%0d required 0", $signed(s));
        end
        vol = '0;
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(3000)) begin
            miscompares++;
            $display("FAIL vol_restore: sample=%0d required 3000", $signed(s));
        end
    endtask

    task automatic test_voice_disable;
        logic [SW-1:0] s;
        int lat;
        int exp_s [7];
        exp_s = '{0, 2000, 4000, 3000, 4000, 5000, 7000};
        apply_reset;
        fill_ramp(0);
        voice_en  = 4'b0011;
        phase_inc = {24'h0, 24'h0, 24'h010000, 24'h010000};
        vol       = '0;
        for (int f = 0; f < 7; f++) begin
            if (f == 5) voice_en = 4'b0011;
            if (f == 2) run_frame(1, '0, 4'b0010, s, lat);
            else        run_frame(-1, '0, '0, s, lat);
            vectors++;
            if (s !== SW'(exp_s[f])) begin
                miscompares++;
                $display("FAIL voice_disable frame %0d: sample=%0d required %0d",
                         f, $signed(s), exp_s[f]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [SW-1:0] s;
        int lat;
        logic seen_valid;
        apply_reset;
        fill_ramp(7);
        voice_en  = 4'b1111;
        phase_inc = {4{24'h010000}};
        vol       = '0;
        run_frame(-1, '0, '0, s, lat);
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(4028)) begin
            miscompares++;
            $display("FAIL pre_reset_frame: sample=%0d required 4028", $signed(s));
        end
        sample_req = 1'b1;
        @(posedge CLOCK_50);
        #1;
        @(posedge CLOCK_50);
        #1 sample_req = 1'b0;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_overrun: overrun=%b required 1", overrun);
        end
        @(posedge CLOCK_50);
        #4 reset = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || sample !== '0 || overrun !== 1'b0 ||
            sample_valid !== 1'b0 || rom_addr !== '0) begin
            miscompares++;
            $display("FAIL midframe_reset: busy=%b sample=%h overrun=%b valid=%b addr=%h required all 0",
                     busy, sample, overrun, sample_valid, rom_addr);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLOCK_50);
            #1;
            if (sample_valid) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL aborted_frame_valid: valid seen=%b required 0", seen_valid);
        end
        run_frame(-1, '0, '0, s, lat);
        vectors++;
        if (s !== SW'(28) || lat != 5) begin
            miscompares++;
            $display("FAIL post_reset_addr0: sample=%0d lat=%0d required 28 lat 5", $signed(s), lat);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sample_req  = 1'b0;
        voice_en    = '0;
        phase_inc   = '0;
        vol         = '0;
        fill_const('0);
        test_reset;
        test_single_voice;
        test_attenuation;
        test_saturation;
        test_back_to_back;
        test_shadowing;
        test_voice_disable;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wavetable_mixer.md
# wavetable_mixer

Parametrised multi-voice wavetable synthesizer for the audio path, the next generation of our fixed four-voice clock-divider synthesizer. Each voice uses a phase accumulator with a programmable frequency word, per-voice multi-level attenuation, and saturating mixing. All voices share one wavetable ROM port, which is time-multiplexed across voices. The block produces one mixed sample per `sample_req` strobe from the audio codec interface.

## Interface
- `NUM_VOICES`, 4: number of voices, ≥1.
- `SAMPLE_W`, 32: signed sample width, for ROM data and output.
- `PHASE_W`, 24: phase accumulator width.
- `TABLE_AW`, 8: wavetable address width, ≤ `PHASE_W`.
- `VOL_W`, 3: per-voice attenuation code width.

Ports:
- `CLOCK_50`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_req`  in  1  one-cycle request for a new sample (codec FIFO has space).
- `voice_en`  in  `NUM_VOICES`  per-voice enable.
- `phase_inc`  in  `NUM_VOICES*PHASE_W`  frequency words; voice i occupies bits [i*PHASE_W +: PHASE_W].
- `vol`  in  `NUM_VOICES*VOL_W`  attenuation codes, packed the same way.
- `rom_addr`  out  `TABLE_AW`  shared wavetable address.
- `rom_q`  in  `SAMPLE_W`  ROM data. The ROM is synchronous with 1-cycle latency: the address is registered at an edge and `rom_q` is valid during the following cycle.
- `sample`  out  `SAMPLE_W`  signed mixed sample; holds its value between frames.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.
- `busy`  out  1  high while a frame is in progress.
- `overrun`  out  1  sticky flag: a `sample_req` arrived while busy.

## Operation
- States are IDLE and RUN.
- **IDLE:**
  - `busy`=0.
  - When `sample_req`=1 at an edge (T0): capture `voice_en`, `phase_inc` and `vol` into shadow registers, clear the accumulator, set idx=0, and go to RUN.
  - Input changes during a frame take effect only at the next T0.
- **RUN:**
  - `rom_addr` = phase[idx][PHASE_W-1 -: TABLE_AW], driven combinationally from idx while idx < `NUM_VOICES`.
  - idx increments at each edge.
  - At the edge where voice k's address is registered (T(k+1)): if the shadowed enable is set, phase[k] += inc[k], modulo 2^PHASE_W. If it is clear, phase[k] is forced to 0.
  - At edge T(k+2), voice k's data is accumulated: acc += att(k). Here att = 0 if voice k is disabled or vol = all-ones (mute); otherwise att = `rom_q` >>> vol (arithmetic shift).
  - The accumulator is `SAMPLE_W`+ceil(log2(`NUM_VOICES`))+1 bits wide, sign-extended, so it cannot overflow internally.
- **Frame end:**
  - At edge T(`NUM_VOICES`+1), the last voice is accumulated.
  - `sample` <= sum clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - `sample_valid` <= 1 for one cycle; the state returns to IDLE.
- **Overrun:**
  - A `sample_req`=1 sampled at any edge while in RUN is ignored and sets `overrun`.
  - This includes the final edge T(`NUM_VOICES`+1).
  - `overrun` is cleared only by reset.
- **Reset** (asynchronous, may occur mid-frame): state=IDLE, idx=0, all phases=0, accumulator=0, shadow registers=0, `sample`=0, `sample_valid`=0, `busy`=0, `overrun`=0, `rom_addr`=0. No `sample_valid` is emitted for an aborted frame.

## Timing
- Latency is `NUM_VOICES`+1 edges from acceptance to the update of `sample` and `sample_valid`. With the default, T0 accepts and T5 outputs.
- `busy`=1 from T0 through T(`NUM_VOICES`+1), then returns to 0.
- Minimum frame spacing is `NUM_VOICES`+2 cycles: a request held continuously high is accepted at T0, T6, T12, …
- Phase wraps naturally, so the table address wraps from 2^TABLE_AW-1 to 0 with no discontinuity handling.
- `rom_addr` is don't-care outside RUN, but it must be 0 after reset.
- The first sample after enabling a voice reads address 0, because the phase starts at 0 and increments after the read.

## Test plan
- **Single voice, defaults.**
  - Stimulus: ROM model rom[a]=a*1000; `voice_en`=0001; inc0=0x010000; vol=0; single `sample_req` pulses.
  - Required: `sample` = 0, 1000, 2000, 3000, …, each with `sample_valid` exactly 5 edges after the request. After 256 frames the address wraps back to 0 (`sample`=0).
- **Attenuation.**
  - Stimulus: rom[1]=1000 read at vol=2, then vol=7.
  - Required: 250 at vol=2; 0 at vol=7 (mute).
  - Stimulus: rom=-1000 with vol=1.
  - Required: -500.
- **Saturation.**
  - Stimulus: all four voices enabled, rom=0x7000_0000.
  - Required: `sample`=0x7FFF_FFFF.
  - Stimulus: rom=0x9000_0000.
  - Required: `sample`=0x8000_0000.
  - Stimulus: two voices at +0x4000_0000 and -0x1000_0000.
  - Required: 0x3000_0000.
- **Overrun and shadowing.**
  - Stimulus: `sample_req` held high for 20 cycles.
  - Required: acceptances at T0, T6, T12, T18; `overrun`=1 and it stays set after `sample_req` falls.
  - Stimulus: change `vol` at T2.
  - Required: the current frame uses the old `vol`.
- **Voice disable.**
  - Stimulus: disable voice 0 mid-stream.
  - Required: its contribution is 0 starting with the next frame.
  - Stimulus: re-enable voice 0.
  - Required: it restarts from address 0.
- **Reset mid-frame.**
  - Stimulus: assert `reset` between T2 and T3, asynchronously.
  - Required: immediately `busy`=0, `sample`=0, `overrun`=0; no `sample_valid` pulse. The next frame reads address 0 for all voices.
